// File: rtl/swb_pkg.sv
// Shared definitions for the store write buffer.
// Holds the default geometry (depth and widths), the pointer and counter
// widths derived from it, and the entry record that describes one buffered
// store.
package swb_pkg;

  localparam int SWB_DEPTH  = 4;
  localparam int SWB_ADDR_W = 32;
  localparam int SWB_DATA_W = 32;

  // Pointers index DEPTH slots.
  localparam int SWB_PTR_W = $clog2(SWB_DEPTH);
  // The occupancy counter must reach DEPTH itself, so it needs one extra code.
  localparam int SWB_CNT_W = $clog2(SWB_DEPTH + 1);

  // One buffered store in the default configuration.
  typedef struct packed {
    logic                  valid;
    logic [SWB_ADDR_W-1:0] addr;
    logic [SWB_DATA_W-1:0] data;
  } swb_entry_t;

endpackage

// File: rtl/swb_fwd_match.sv
// Youngest-match search for load forwarding.
// Compares a load address against every valid buffered entry. When several
// entries match, the data of the most recently written one is returned.
//
// Ports:
//   lookup_i  load lookup request; when low the outputs are forced to zero
//   raddr_i   load address
//   valid_i   per-slot valid bits
//   addr_i    per-slot store addresses
//   data_i    per-slot store data
//   tail_i    next write slot; tail_i-1 holds the youngest entry
//   hit_o     at least one valid slot matches raddr_i
//   data_o    data of the youngest matching slot, zero when no hit
module swb_fwd_match
  import swb_pkg::*;
#(
  parameter int DEPTH  = SWB_DEPTH,
  parameter int ADDR_W = SWB_ADDR_W,
  parameter int DATA_W = SWB_DATA_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic                          lookup_i,
  input  logic [ADDR_W-1:0]             raddr_i,
  input  logic [DEPTH-1:0]              valid_i,
  input  logic [DEPTH-1:0][ADDR_W-1:0]  addr_i,
  input  logic [DEPTH-1:0][DATA_W-1:0]  data_i,
  input  logic [PTR_W-1:0]              tail_i,
  output logic                          hit_o,
  output logic [DATA_W-1:0]             data_o
);

  logic [PTR_W-1:0] idx;

  // Walk the slots from the oldest position (tail) to the youngest
  // (tail-1) so that later matches overwrite earlier ones and the youngest
  // match wins. Slots outside the head..tail window have their valid bit
  // clear, so the head pointer is not needed to bound the search.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    if (lookup_i) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        idx = tail_i - PTR_W'(k + 1);
        if (valid_i[idx] && (addr_i[idx] == raddr_i)) begin
          hit_o  = 1'b1;
          data_o = data_i[idx];
        end
      end
    end
  end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-write buffer between the core store path and data memory.
// Stores are accepted in one cycle, drained in FIFO order over a valid/ready
// handshake, and the youngest buffered data is forwarded to loads. A full
// buffer raises stall so the core holds its store.
//
// Ports:
//   clk, rst              clock and asynchronous active-low reset
//   cpu_we/addr/wdata     store request from the core
//   cpu_re/raddr          load lookup from the core
//   fwd_hit/fwd_data      forwarding result for the load lookup
//   stall                 buffer full, core must hold the store
//   mem_valid/ready       drain handshake toward data memory
//   mem_addr/wdata        head entry being drained (zero when empty)
//   empty, count          occupancy status
module store_write_buffer
  import swb_pkg::*;
#(
  parameter int DEPTH  = SWB_DEPTH,
  parameter int ADDR_W = SWB_ADDR_W,
  parameter int DATA_W = SWB_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_we,
  input  logic [ADDR_W-1:0]          cpu_addr,
  input  logic [DATA_W-1:0]          cpu_wdata,
  input  logic                       cpu_re,
  input  logic [ADDR_W-1:0]          cpu_raddr,
  output logic                       fwd_hit,
  output logic [DATA_W-1:0]          fwd_data,
  output logic                       stall,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]             head_q, head_d;
  logic [PTR_W-1:0]             tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;

  logic push;
  logic pop;

  // Status comes only from the registered count, so mem_ready can never
  // reach stall combinationally.
  assign stall     = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign mem_valid = !empty;
  assign count     = count_q;

  // Storage payload is not reset, so the drain port is masked while empty.
  assign mem_addr  = empty ? '0 : addr_q[head_q];
  assign mem_wdata = empty ? '0 : data_q[head_q];

  // A store offered while full is dropped; the core keeps it stable and
  // retries once stall falls.
  assign push = cpu_we && !stall;
  assign pop  = mem_valid && mem_ready;

  // Next-state for pointers, valid bits and occupancy. Push and pop never
  // touch the same slot: that would need the buffer to be both empty and
  // full at once.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards any pending stores.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Payload write at the tail slot.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= cpu_addr;
      data_q[tail_q] <= cpu_wdata;
    end
  end

  swb_fwd_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PTR_W  (PTR_W)
  ) u_fwd_match (
    .lookup_i (cpu_re),
    .raddr_i  (cpu_raddr),
    .valid_i  (valid_q),
    .addr_i   (addr_q),
    .data_i   (data_q),
    .tail_i   (tail_q),
    .hit_o    (fwd_hit),
    .data_o   (fwd_data)
  );

endmodule

// File: tb/tb_store_write_buffer.sv
// Testbench for store_write_buffer.
// The driver keeps a queue-based model of the buffer contents and checks the
// status and forwarding outputs every cycle; accepted stores are also pushed
// into a scoreboard that a separate monitor pops on each drain handshake.
module tb_store_write_buffer;
  import swb_pkg::*;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_re = 1'b0;
  logic [ADDR_W-1:0] cpu_raddr = '0;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic              stall;
  logic              mem_valid;
  logic              mem_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              empty;
  logic [$clog2(DEPTH+1)-1:0] count;

  int checks   = 0;
  int failures = 0;

  swb_entry_t bufModel[$];
  swb_entry_t expQ[$];
  swb_entry_t monEntry;
  bit         lastAccepted = 1'b0;

  store_write_buffer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_re    (cpu_re),
    .cpu_raddr (cpu_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .stall     (stall),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .empty     (empty),
    .count     (count)
  );

  // 10-unit clock; rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Single comparison point: every check goes through here.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Compare every status output with what the model buffer implies for the
  // current cycle, before the upcoming clock edge takes effect.
  task automatic checkState();
    logic              expHit;
    logic [DATA_W-1:0] expData;
    int                n;
    n       = bufModel.size();
    expHit  = 1'b0;
    expData = '0;
    if (cpu_re) begin
      for (int i = n - 1; i >= 0; i--) begin
        if (bufModel[i].addr == cpu_raddr) begin
          expHit  = 1'b1;
          expData = bufModel[i].data;
          break;
        end
      end
    end
    checkOutput("count", count, n);
    checkOutput("empty", empty, n == 0);
    checkOutput("stall", stall, n == DEPTH);
    checkOutput("memValid", mem_valid, n != 0);
    checkOutput("memAddr", mem_addr, (n == 0) ? 0 : bufModel[0].addr);
    checkOutput("memWdata", mem_wdata, (n == 0) ? 0 : bufModel[0].data);
    checkOutput("fwdHit", fwd_hit, expHit);
    checkOutput("fwdData", fwd_data, expData);
  endtask

  // One core cycle: drive inputs after the falling edge, check, then advance
  // the model to what the next rising edge should produce.
  task automatic applyStimulus(input bit we, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input bit ready,
                               input bit re, input logic [ADDR_W-1:0] raddr);
    bit         accept;
    bit         doPop;
    swb_entry_t e;
    @(negedge clk);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
    mem_ready = ready;
    cpu_re    = re;
    cpu_raddr = raddr;
    #1;
    checkState();
    accept = we && (bufModel.size() < DEPTH);
    doPop  = ready && (bufModel.size() > 0);
    if (doPop) void'(bufModel.pop_front());
    if (accept) begin
      e.valid = 1'b1;
      e.addr  = addr;
      e.data  = data;
      bufModel.push_back(e);
      expQ.push_back(e);
    end
    lastAccepted = accept;
  endtask

  task automatic drainAll();
    for (int n = 0; n < DEPTH + 2 && bufModel.size() > 0; n++)
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
  endtask

  // Drain monitor: on every accepted handshake, the head must be the oldest
  // store still outstanding in the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (rst && mem_valid && mem_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("drainUnexpected", 1, 0);
        end else begin
          monEntry = expQ.pop_front();
          checkOutput("drainAddr", mem_addr, monEntry.addr);
          checkOutput("drainData", mem_wdata, monEntry.data);
        end
      end
    end
  end

  initial begin
    bit                lastWe;
    logic [ADDR_W-1:0] hAddr;
    logic [DATA_W-1:0] hData;
    bit                we;

    // Reset state, with a lookup active to show forwarding is off.
    cpu_re = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rstCount", count, 0);
    checkOutput("rstEmpty", empty, 1);
    checkOutput("rstStall", stall, 0);
    checkOutput("rstMemValid", mem_valid, 0);
    checkOutput("rstFwdHit", fwd_hit, 0);
    checkOutput("rstFwdData", fwd_data, 0);
    checkOutput("rstMemAddr", mem_addr, 0);
    checkOutput("rstMemWdata", mem_wdata, 0);
    cpu_re = 1'b0;
    rst    = 1'b1;

    // Single store drains one cycle after it is accepted.
    $display("[TB] single store and drain");
    applyStimulus(1'b1, 32'h15, 32'hDEADBEEF, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    checkOutput("t1MemAddr", mem_addr, 32'h15);
    checkOutput("t1MemWdata", mem_wdata, 32'hDEADBEEF);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, '0);
    checkOutput("t1Empty", empty, 1);

    // Fill to full, hold the fifth store, free one slot.
    $display("[TB] full and stall");
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'h100 + i, 32'hA000 + i, 1'b0, 1'b0, '0);
    checkOutput("t2StallFull", stall, 1);
    checkOutput("t2CountFull", count, 4);
    applyStimulus(1'b1, 32'h104, 32'hA004, 1'b1, 1'b0, '0);
    checkOutput("t2StallSameCycle", stall, 1);
    applyStimulus(1'b1, 32'h104, 32'hA004, 1'b0, 1'b0, '0);
    checkOutput("t2StallReleased", stall, 0);
    drainAll();

    // Youngest match wins; a different address misses.
    $display("[TB] forwarding");
    applyStimulus(1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0, '0);
    applyStimulus(1'b1, 32'h20, 32'h22222222, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 32'h20);
    checkOutput("t3FwdHit", fwd_hit, 1);
    checkOutput("t3FwdData", fwd_data, 32'h22222222);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 32'h24);
    checkOutput("t3MissHit", fwd_hit, 0);
    checkOutput("t3MissData", fwd_data, 0);

    // Simultaneous push and pop at count 2 across the pointer wrap.
    $display("[TB] push and pop together");
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 32'h300 + 4 * i, 32'hB000 + i, 1'b1, 1'b0, '0);
    checkOutput("t4Count", count, 2);
    drainAll();

    // Held drain request stays stable until accepted; the entry being
    // popped is still forwardable.
    $display("[TB] drain backpressure");
    applyStimulus(1'b1, 32'h500, 32'hC0FFEE00, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
      checkOutput("t5Valid", mem_valid, 1);
      checkOutput("t5Addr", mem_addr, 32'h500);
      checkOutput("t5Data", mem_wdata, 32'hC0FFEE00);
    end
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 32'h500);
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);

    // Asynchronous reset mid-cycle discards pending stores.
    $display("[TB] asynchronous reset");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h600 + 4 * i, 32'hD000 + i, 1'b0, 1'b0, '0);
    @(negedge clk);
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    checkOutput("t6Empty", empty, 1);
    checkOutput("t6MemValid", mem_valid, 0);
    checkOutput("t6Count", count, 0);
    bufModel.delete();
    expQ.delete();
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 32'h600);
    applyStimulus(1'b0, '0, '0, 1'b1, 1'b1, 32'h608);

    // Random traffic over a small address pool to provoke forwarding hits.
    $display("[TB] random traffic");
    lastWe = 1'b0;
    hAddr  = '0;
    hData  = '0;
    for (int c = 0; c < 400; c++) begin
      if (lastWe && !lastAccepted) begin
        we = 1'b1;
      end else begin
        we    = ($urandom_range(0, 1) == 1);
        hAddr = 32'h40 + 4 * $urandom_range(0, 5);
        hData = $urandom;
      end
      applyStimulus(we, hAddr, hData, ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 1) == 1), 32'h40 + 4 * $urandom_range(0, 6));
      lastWe = we;
    end
    drainAll();
    applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, '0);
    checkOutput("scoreboardEmpty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
